// File: rtl/div_ctrl_pkg.sv
// Shared types and constants for the multi-cycle divide sequencer.
package div_ctrl_pkg;

    localparam int unsigned DATA_W     = 32;
    localparam int unsigned DIV_CYCLES = 32;
    localparam int unsigned CNT_W      = 6;
    localparam int unsigned PART_W     = 2 * DATA_W + 1;

    typedef enum logic [1:0] {
        DIV_IDLE   = 2'b00,
        DIV_BYZERO = 2'b01,
        DIV_ON     = 2'b10,
        DIV_DONE   = 2'b11
    } div_state_e;

    // HI/LO payload: remainder in the upper word, quotient in the lower word
    typedef struct packed {
        logic [DATA_W-1:0] rem;
        logic [DATA_W-1:0] quo;
    } div_result_t;

    function automatic logic [DATA_W-1:0] neg32(input logic [DATA_W-1:0] x);
        return DATA_W'(~x + DATA_W'(1));
    endfunction

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division iteration on the 65-bit partial.
module div_step
    import div_ctrl_pkg::*;
(
    input  logic [PART_W-1:0] partial,
    input  logic [DATA_W-1:0] divisor,
    output logic [PART_W-1:0] next_partial
);

    logic [DATA_W:0] trial;
    logic            unused_top;

    assign unused_top = partial[PART_W-1];
    assign trial      = {1'b0, partial[2*DATA_W-1:DATA_W]} - {1'b0, divisor};

    // Negative trial keeps the remainder and shifts in a 0 quotient bit
    always_comb begin
        next_partial = {partial[PART_W-2:0], 1'b0};
        if (!trial[DATA_W]) begin
            next_partial = {trial[DATA_W-1:0], partial[DATA_W-1:0], 1'b1};
        end
    end

endmodule

// File: rtl/div_ctrl.sv
// 32-bit DIV/DIVU sequencer: 32 restoring iterations, result packed {rem, quo}.
// Define DIV_SIGNED_EN to honour signed_div; otherwise every divide is unsigned.
module div_ctrl
    import div_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               signed_div,
    input  logic [DATA_W-1:0]  opdata1,
    input  logic [DATA_W-1:0]  opdata2,
    input  logic               annul,
    output logic [2*DATA_W-1:0] result,
    output logic               ready,
    output logic               busy
);

    div_state_e          state;
    logic [CNT_W-1:0]    counter;
    logic [PART_W-1:0]   partial;
    logic [PART_W-1:0]   next_partial;
    logic [DATA_W-1:0]   divisor;
    logic [DATA_W-1:0]   mag1;
    logic [DATA_W-1:0]   mag2;
    logic [DATA_W-1:0]   quo_fix;
    logic [DATA_W-1:0]   rem_fix;
    logic                unused_bit;

    assign unused_bit = partial[DATA_W];

`ifdef DIV_SIGNED_EN
    logic neg1;
    logic neg2;
    logic quo_neg;
    logic rem_neg;

    assign neg1    = signed_div & opdata1[DATA_W-1];
    assign neg2    = signed_div & opdata2[DATA_W-1];
    assign mag1    = neg1 ? neg32(opdata1) : opdata1;
    assign mag2    = neg2 ? neg32(opdata2) : opdata2;
    assign quo_fix = quo_neg ? neg32(partial[DATA_W-1:0]) : partial[DATA_W-1:0];
    assign rem_fix = rem_neg ? neg32(partial[PART_W-1:DATA_W+1])
                             : partial[PART_W-1:DATA_W+1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            quo_neg <= 1'b0;
            rem_neg <= 1'b0;
        end else if (state == DIV_IDLE && start && !annul) begin
            quo_neg <= neg1 ^ neg2;
            rem_neg <= neg1;
        end
    end
`else
    logic unused_signed;

    assign unused_signed = signed_div;
    assign mag1          = opdata1;
    assign mag2          = opdata2;
    assign quo_fix       = partial[DATA_W-1:0];
    assign rem_fix       = partial[PART_W-1:DATA_W+1];
`endif

    div_step u_step (
        .partial      (partial),
        .divisor      (divisor),
        .next_partial (next_partial)
    );

    // Sequencer; annul outranks both acceptance and completion
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= DIV_IDLE;
            result  <= '0;
            ready   <= 1'b0;
            busy    <= 1'b0;
            counter <= '0;
            partial <= '0;
            divisor <= '0;
        end else begin
            case (state)
                DIV_IDLE: begin
                    ready <= 1'b0;
                    if (start && !annul) begin
                        busy <= 1'b1;
                        if (opdata2 == '0) begin
                            state <= DIV_BYZERO;
                        end else begin
                            state   <= DIV_ON;
                            partial <= {DATA_W'(0), mag1, 1'b0};
                            divisor <= mag2;
                            counter <= '0;
                        end
                    end
                end
                DIV_BYZERO: begin
                    busy <= 1'b0;
                    if (annul) begin
                        state <= DIV_IDLE;
                        ready <= 1'b0;
                    end else begin
                        state  <= DIV_DONE;
                        result <= '0;
                        ready  <= 1'b1;
                    end
                end
                DIV_ON: begin
                    if (annul) begin
                        state <= DIV_IDLE;
                        ready <= 1'b0;
                        busy  <= 1'b0;
                    end else if (counter == CNT_W'(DIV_CYCLES)) begin
                        state  <= DIV_DONE;
                        result <= div_result_t'{rem: rem_fix, quo: quo_fix};
                        ready  <= 1'b1;
                        busy   <= 1'b0;
                    end else begin
                        partial <= next_partial;
                        counter <= counter + CNT_W'(1);
                    end
                end
                default: begin
                    state <= DIV_IDLE;
                    ready <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
